// File: rtl/majority_bist.sv
// Self-checking exerciser for an N-input majority voter: sweeps all input
// vectors, samples z_in after a settle window, and compares it to a popcount reference.
module majority_bist #(
    parameter int WIDTH  = 5,
    parameter int THRESH = WIDTH / 2 + 1,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] x_out,
    input  logic             z_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic             first_fail_valid,
    output logic [WIDTH-1:0] first_fail_vec
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]    HOLD_LAST = CW'(SETTLE - 1);
    localparam logic [WIDTH:0]   ERR_MAX   = '1;
    localparam logic [WIDTH-1:0] VEC_LAST  = '1;
    localparam logic [WIDTH:0]   THR       = (WIDTH + 1)'(THRESH);

    logic [1:0]       state;
    logic [WIDTH-1:0] vec;
    logic [CW-1:0]    hold_cnt;
    logic [WIDTH:0]   pop;
    logic             expected;
    logic             mismatch;
    logic [WIDTH:0]   err_next;

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop = pop + {{WIDTH{1'b0}}, vec[i]};
        end
    end

    assign expected = (pop >= THR);
    assign mismatch = (state == S_SAMPLE) && (z_in != expected);

    // Saturate so a long-running fault can never wrap back to a clean count.
    always_comb begin
        err_next = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            err_next = err_count + (WIDTH + 1)'(1);
        end
    end

    assign busy  = (state == S_HOLD) || (state == S_SAMPLE);
    assign done  = (state == S_FINISH);
    assign x_out = busy ? vec : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            vec              <= '0;
            hold_cnt         <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            pass             <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state            <= S_HOLD;
                        vec              <= '0;
                        hold_cnt         <= '0;
                        err_count        <= '0;
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
                        pass             <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= S_SAMPLE;
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                S_SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch && !first_fail_valid) begin
                        first_fail_valid <= 1'b1;
                        first_fail_vec   <= vec;
                    end
                    // pass must include this final sample, hence err_next.
                    if (vec == VEC_LAST) begin
                        state <= S_FINISH;
                        pass  <= (err_next == '0);
                    end else begin
                        vec      <= vec + WIDTH'(1);
                        hold_cnt <= '0;
                        state    <= S_HOLD;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_majority_bist.sv
// Bench for majority_bist: cycle-indexed sweep model plus directed fault scenarios
// (golden, stuck-at-0/1, inverted voter, mid-sweep start, mid-sweep reset).
module tb_majority_bist;

    localparam int W        = 5;
    localparam int TH       = 3;
    localparam int S        = 1;
    localparam int NV       = 32;
    localparam int BUSY_LEN = NV * (S + 1);
    localparam int MAXE     = 2 ** (W + 1) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         z_in;
    logic [W-1:0] x_out;
    logic         busy;
    logic         done;
    logic         pass;
    logic [W:0]   err_count;
    logic         first_fail_valid;
    logic [W-1:0] first_fail_vec;
    int           mode = 0;

    int errors = 0;
    int checks = 0;

    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    bit           m_pass = 1'b0;
    bit           m_ffv = 1'b0;
    logic [W-1:0] m_ffvec = '0;
    int           m_t = 0;
    int           m_err = 0;
    int           busy_cnt = 0;
    int           done_cnt = 0;

    majority_bist #(.WIDTH(W), .THRESH(TH), .SETTLE(S)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .x_out            (x_out),
        .z_in             (z_in),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec)
    );

    always #5 clk = ~clk;

    // 0 golden, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
    function automatic logic voter(int md, logic [W-1:0] v);
        logic maj;
        maj = ($countones(v) >= TH);
        case (md)
            1: return 1'b0;
            2: return 1'b1;
            3: return !maj;
            default: return maj;
        endcase
    endfunction

    assign z_in = voter(mode, x_out);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare();
        logic [31:0] exp_x;
        exp_x = m_busy ? m_t / (S + 1) : 0;
        check("busy", busy, m_busy);
        check("done", done, m_done);
        check("x_out", x_out, exp_x);
        check("err_count", err_count, m_err);
        check("pass", pass, m_pass);
        check("ff_valid", first_fail_valid, m_ffv);
        check("ff_vec", first_fail_vec, m_ffvec);
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (m_busy && (m_t % (S + 1) == S)) begin
            $display("x1x2x3x4x5=%b, z1=%b", x_out, z_in);
        end
    endtask

    task automatic model_step();
        logic [W-1:0] v;
        if (rst) begin
            m_busy = 0; m_done = 0; m_pass = 0;
            m_ffv = 0; m_ffvec = '0; m_t = 0; m_err = 0;
        end else if (m_busy) begin
            if (m_t % (S + 1) == S) begin
                v = W'(m_t / (S + 1));
                if (voter(mode, v) != ($countones(v) >= TH)) begin
                    if (m_err < MAXE) m_err++;
                    if (!m_ffv) begin
                        m_ffv = 1;
                        m_ffvec = v;
                    end
                end
            end
            m_t++;
            if (m_t == BUSY_LEN) begin
                m_busy = 0;
                m_done = 1;
                m_pass = (m_err == 0);
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start) begin
            m_busy = 1; m_t = 0; m_err = 0;
            m_ffv = 0; m_ffvec = '0; m_pass = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic sweep(input int md, input int mid, input bit fin,
                         input int exp_err, input logic [W-1:0] exp_vec,
                         input bit exp_ffv, input bit exp_pass,
                         input string tag);
        int b0;
        int d0;
        bit seen;
        b0 = busy_cnt;
        d0 = done_cnt;
        seen = 0;
        mode = md;
        start = 1'b1;
        cycle();
        for (int i = 0; i < 200 && !seen; i++) begin
            start = (i == mid) || (fin && m_done);
            cycle();
            if (done_cnt != d0) seen = 1;
        end
        start = 1'b0;
        cycle();
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_err"}, err_count, exp_err);
        check({tag, "_ffvec"}, first_fail_vec, exp_vec);
        check({tag, "_ffv"}, first_fail_valid, exp_ffv);
        check({tag, "_pass"}, pass, exp_pass);
        check({tag, "_busy_len"}, busy_cnt - b0, BUSY_LEN);
        check({tag, "_done_cnt"}, done_cnt - d0, 1);
    endtask

    initial begin
        bit found;
        int d0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        check("rst_x_out", x_out, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err_count, 0);

        sweep(0, -1, 0, 0, 5'b00000, 0, 1, "golden");
        sweep(1, -1, 0, 16, 5'b00111, 1, 0, "stuck0");
        sweep(2, -1, 0, 16, 5'b00000, 1, 0, "stuck1");
        sweep(3, -1, 0, 32, 5'b00000, 1, 0, "invert");
        sweep(0, 20, 1, 0, 5'b00000, 0, 1, "restart");
        sweep(0, -1, 0, 0, 5'b00000, 0, 1, "after_done");

        mode = 1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_busy && (m_t / (S + 1) == 10)) found = 1;
            else cycle();
        end
        check("vec10_reached", found, 1);
        check("pre_rst_err", err_count, 1);
        check("pre_rst_ffvec", first_fail_vec, 5'b00111);
        d0 = done_cnt;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("midrst_x_out", x_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err", err_count, 0);
        check("midrst_pass", pass, 0);
        repeat (5) cycle();
        check("midrst_no_done", done_cnt - d0, 0);

        sweep(0, -1, 0, 0, 5'b00000, 0, 1, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
